// File: rtl/edit_ctrl_pkg.sv
// Shared types and constants for the hex operand editor mode controller.
package edit_ctrl_pkg;

  typedef enum logic [1:0] {
    VIEW   = 2'd0,
    EDIT_A = 2'd1,
    EDIT_B = 2'd2
  } mode_t;

  localparam logic [3:0] CTRL_VIEW   = 4'b0000;
  localparam logic [3:0] CTRL_EDIT_A = 4'b0001;
  localparam logic [3:0] CTRL_EDIT_B = 4'b0011;

  localparam logic [1:0] DISP_A   = 2'd0;
  localparam logic [1:0] DISP_B   = 2'd1;
  localparam logic [1:0] DISP_RES = 2'd2;

  localparam int BTN_C = 0;
  localparam int BTN_D = 1;
  localparam int BTN_R = 2;
  localparam int BTN_U = 3;
  localparam int BTN_L = 4;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      VIEW:    return EDIT_A;
      EDIT_A:  return EDIT_B;
      default: return VIEW;
    endcase
  endfunction

endpackage

// File: rtl/edit_ctrl_if.sv
// Button and mode signals between the board pins, edit_ctrl and the editor / display mux.
interface edit_ctrl_if;
  logic [4:0] btn_raw;
  logic [4:0] BTN_OK;
  logic [3:0] ctrl;
  logic [1:0] disp_sel;
  logic [1:0] mode;

  modport master (output btn_raw, input BTN_OK, ctrl, disp_sel, mode);
  modport slave  (input btn_raw, output BTN_OK, ctrl, disp_sel, mode);
endinterface

// File: rtl/btn_debounce.sv
// One push-button: two-flop synchronizer, stability counter and rising-edge pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES < 3) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic          stable_d_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      stable_reg   <= 1'b0;
      stable_d_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      sync1_reg    <= raw;
      sync2_reg    <= sync1_reg;
      stable_d_reg <= stable_reg;
      // any bounce back to the accepted level restarts the count
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign stable = stable_reg;
  assign press  = stable_reg & ~stable_d_reg;

endmodule

// File: rtl/edit_ctrl.sv
// Mode controller: debounces five buttons, runs VIEW/EDIT_A/EDIT_B with inactivity
// timeout and forwards arrow presses to the editor only while editing.
module edit_ctrl
  import edit_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 500_000_000
) (
  input  logic        clk,
  input  logic        rst,
  edit_ctrl_if.slave  bus
);

  localparam int IW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] TO_LAST = IW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  mode_t         state_reg;
  logic [IW-1:0] idle_reg;
  logic [4:0]    btn_ok_reg;
  logic [4:0]    press;
  // Debounced levels are not needed here; only the press edges drive the FSM.
  logic [4:0]    stable_unused;
  logic          in_edit;
  logic [3:0]    ctrl_dec;
  logic [1:0]    disp_dec;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .raw    (bus.btn_raw[gi]),
        .stable (stable_unused[gi]),
        .press  (press[gi])
      );
    end
  endgenerate

  assign in_edit = (state_reg != VIEW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= VIEW;
      idle_reg   <= '0;
      btn_ok_reg <= '0;
    end else begin
      // a centre press in the same cycle swallows any arrow pulses
      btn_ok_reg <= (in_edit && !press[BTN_C]) ? {press[BTN_L:BTN_D], 1'b0} : 5'b0;

      if (press[BTN_C]) begin
        state_reg <= next_mode(state_reg);
        idle_reg  <= '0;
      end else if (!in_edit || press != 5'b0) begin
        idle_reg <= '0;
      end else if (TIMEOUT_CYCLES != 0 && idle_reg == TO_LAST) begin
        state_reg <= VIEW;
        idle_reg  <= '0;
      end else if (idle_reg != '1) begin
        idle_reg <= idle_reg + 1'b1;
      end
    end
  end

  always_comb begin
    ctrl_dec = CTRL_VIEW;
    disp_dec = DISP_RES;
    case (state_reg)
      EDIT_A: begin
        ctrl_dec = CTRL_EDIT_A;
        disp_dec = DISP_A;
      end
      EDIT_B: begin
        ctrl_dec = CTRL_EDIT_B;
        disp_dec = DISP_B;
      end
      default: begin
        ctrl_dec = CTRL_VIEW;
        disp_dec = DISP_RES;
      end
    endcase
  end

  assign bus.BTN_OK   = btn_ok_reg;
  assign bus.ctrl     = ctrl_dec;
  assign bus.disp_sel = disp_dec;
  assign bus.mode     = state_reg;

endmodule

// File: tb/tb_edit_ctrl.sv
// Bench for edit_ctrl: directed scenarios against fixed expectations plus random
// button activity against a cycle-level behavioural model.
module tb_edit_ctrl;

  localparam int DB = 4;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  edit_ctrl_if bus ();

  edit_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int unsigned m_edge = 0;
  int unsigned m_last = 0;
  int          m_mode = 0;
  int          m_run[5] = '{0, 0, 0, 0, 0};
  logic [4:0]  m_s1 = '0;
  logic [4:0]  m_s2 = '0;
  logic [4:0]  m_stable = '0;
  logic [4:0]  m_prev = '0;
  logic [4:0]  m_ok = '0;

  function automatic logic [3:0] exp_ctrl(input int m);
    case (m)
      1:       return 4'b0001;
      2:       return 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [1:0] exp_disp(input int m);
    case (m)
      1:       return 2'd0;
      2:       return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs present before that edge.
  task automatic model_step();
    logic [4:0] pr;
    m_edge++;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0; m_ok = '0;
      for (int i = 0; i < 5; i++) m_run[i] = 0;
      m_mode = 0;
      m_last = m_edge;
    end else begin
      pr   = m_stable & ~m_prev;
      m_ok = (m_mode != 0 && !pr[0]) ? (pr & 5'b11110) : 5'b00000;
      if (pr[0]) begin
        m_mode = (m_mode + 1) % 3;
        m_last = m_edge;
      end else if (m_mode != 0 && pr != 5'b0) begin
        m_last = m_edge;
      end else if (m_mode != 0 && (m_edge - m_last) == TO) begin
        m_mode = 0;
        m_last = m_edge;
      end
      m_prev = m_stable;
      for (int i = 0; i < 5; i++) begin
        if (m_s2[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_stable[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = bus.btn_raw;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.btn_raw = 5'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic hold_press(input logic [4:0] mask, input int hold, input int idle);
    bus.btn_raw = mask;
    repeat (hold) tick();
    bus.btn_raw = 5'b0;
    repeat (idle) tick();
  endtask

  task automatic test_reset();
    logic [1:0] exp_m;
    bus.btn_raw = 5'b11111;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (bus.mode !== 2'd0 || bus.ctrl !== 4'b0000 || bus.disp_sel !== 2'd2 || bus.BTN_OK !== 5'b0) begin
        bad++;
        $display("FAIL reset_state: mode=%0d ctrl=%b disp_sel=%0d BTN_OK=%b, want 0 0000 2 00000",
                 bus.mode, bus.ctrl, bus.disp_sel, bus.BTN_OK);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_m = (k >= 7) ? 2'd1 : 2'd0;
      total++;
      if (bus.mode !== exp_m || bus.BTN_OK !== 5'b0) begin
        bad++;
        $display("FAIL reset_release edge %0d: mode=%0d BTN_OK=%b, want %0d 00000",
                 k, bus.mode, bus.BTN_OK, exp_m);
      end
    end
    bus.btn_raw = 5'b0;
    repeat (8) tick();
  endtask

  task automatic test_centre();
    logic [1:0] exp_m;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      hold_press(5'b00001, 5, 5);
      exp_m = 2'((i + 1) % 3);
      total++;
      if (bus.mode !== exp_m || bus.ctrl !== exp_ctrl(int'(exp_m)) || bus.disp_sel !== exp_disp(int'(exp_m))) begin
        bad++;
        $display("FAIL centre_seq %0d: mode=%0d ctrl=%b disp_sel=%0d, want %0d %b %0d",
                 i, bus.mode, bus.ctrl, bus.disp_sel, exp_m, exp_ctrl(int'(exp_m)), exp_disp(int'(exp_m)));
      end
    end
    hold_press(5'b00001, 3, 10);
    total++;
    if (bus.mode !== 2'd0) begin
      bad++;
      $display("FAIL glitch_view: mode=%0d, want 0", bus.mode);
    end
    hold_press(5'b00001, 5, 5);
    hold_press(5'b00001, 3, 6);
    total++;
    if (bus.mode !== 2'd1) begin
      bad++;
      $display("FAIL glitch_edit: mode=%0d, want 1", bus.mode);
    end
  endtask

  task automatic test_arrow();
    logic [4:0] exp_ok;
    do_reset();
    hold_press(5'b00001, 5, 5);
    bus.btn_raw = 5'b01000;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_ok = (k == 7) ? 5'b01000 : 5'b00000;
      total++;
      if (bus.BTN_OK !== exp_ok) begin
        bad++;
        $display("FAIL arrow_edit edge %0d: BTN_OK=%b, want %b", k, bus.BTN_OK, exp_ok);
      end
    end
    bus.btn_raw = 5'b0;
    repeat (6) tick();
    do_reset();
    bus.btn_raw = 5'b01000;
    for (int k = 1; k <= 9; k++) begin
      tick();
      total++;
      if (bus.BTN_OK !== 5'b0 || bus.mode !== 2'd0) begin
        bad++;
        $display("FAIL arrow_view edge %0d: BTN_OK=%b mode=%0d, want 00000 0", k, bus.BTN_OK, bus.mode);
      end
    end
    bus.btn_raw = 5'b0;
    repeat (6) tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    hold_press(5'b00001, 5, 5);
    bus.btn_raw = 5'b10001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++;
      if (bus.BTN_OK !== 5'b0) begin
        bad++;
        $display("FAIL simul_ok edge %0d: BTN_OK=%b, want 00000", k, bus.BTN_OK);
      end
    end
    total++;
    if (bus.mode !== 2'd2) begin
      bad++;
      $display("FAIL simul_mode: mode=%0d, want 2", bus.mode);
    end
    bus.btn_raw = 5'b0;
    repeat (6) tick();
  endtask

  task automatic enter_edit_b(output bit found);
    found = 1'b0;
    hold_press(5'b00001, 5, 5);
    bus.btn_raw = 5'b00001;
    for (int k = 1; k <= 12 && !found; k++) begin
      tick();
      if (bus.mode == 2'd2) found = 1'b1;
    end
    bus.btn_raw = 5'b0;
    total++;
    if (!found) begin
      bad++;
      $display("FAIL edit_b_entry: mode=%0d after 12 edges, want 2", bus.mode);
    end
  endtask

  task automatic test_timeout();
    bit found;
    logic [1:0] exp_m;
    logic [4:0] exp_ok;
    do_reset();
    enter_edit_b(found);
    if (found) begin
      for (int k = 1; k <= 20; k++) begin
        tick();
        exp_m = (k >= 20) ? 2'd0 : 2'd2;
        total++;
        if (bus.mode !== exp_m) begin
          bad++;
          $display("FAIL timeout_plain edge %0d: mode=%0d, want %0d", k, bus.mode, exp_m);
        end
      end
    end
    enter_edit_b(found);
    if (found) begin
      for (int k = 1; k <= 38; k++) begin
        if (k == 9) bus.btn_raw = 5'b00010;
        if (k == 14) bus.btn_raw = 5'b00000;
        tick();
        exp_m  = (k >= 35) ? 2'd0 : 2'd2;
        exp_ok = (k == 15) ? 5'b00010 : 5'b00000;
        total++;
        if (bus.mode !== exp_m || bus.BTN_OK !== exp_ok) begin
          bad++;
          $display("FAIL timeout_restart edge %0d: mode=%0d BTN_OK=%b, want %0d %b",
                   k, bus.mode, bus.BTN_OK, exp_m, exp_ok);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hold_press(5'b00001, 5, 5);
    hold_press(5'b00001, 5, 5);
    total++;
    if (bus.mode !== 2'd2) begin
      bad++;
      $display("FAIL rmid_setup: mode=%0d, want 2", bus.mode);
    end
    bus.btn_raw = 5'b00100;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    total++;
    if (bus.mode !== 2'd0 || bus.BTN_OK !== 5'b0) begin
      bad++;
      $display("FAIL rmid_reset: mode=%0d BTN_OK=%b, want 0 00000", bus.mode, bus.BTN_OK);
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++;
      if (bus.mode !== 2'd0 || bus.BTN_OK !== 5'b0) begin
        bad++;
        $display("FAIL rmid_after edge %0d: mode=%0d BTN_OK=%b, want 0 00000", k, bus.mode, bus.BTN_OK);
      end
    end
    bus.btn_raw = 5'b0;
    repeat (8) tick();
  endtask

  task automatic test_random();
    int r;
    int hold;
    do_reset();
    for (int t = 0; t < 350; t++) begin
      r = $urandom_range(0, 99);
      rst = (r < 2);
      if (r < 35)      bus.btn_raw = 5'b00001 & 5'($urandom);
      else if (r < 85) bus.btn_raw = 5'($urandom);
      else             bus.btn_raw = 5'b0;
      hold = (r >= 95) ? 25 : $urandom_range(1, 9);
      repeat (hold) begin
        tick();
        total++;
        if (bus.mode !== 2'(m_mode) || bus.BTN_OK !== m_ok ||
            bus.ctrl !== exp_ctrl(m_mode) || bus.disp_sel !== exp_disp(m_mode)) begin
          bad++;
          $display("FAIL random t=%0d: mode=%0d BTN_OK=%b ctrl=%b disp=%0d, want %0d %b %b %0d",
                   t, bus.mode, bus.BTN_OK, bus.ctrl, bus.disp_sel,
                   m_mode, m_ok, exp_ctrl(m_mode), exp_disp(m_mode));
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.btn_raw = 5'b0;
    @(negedge clk);
    test_reset();
    test_centre();
    test_arrow();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edit_ctrl.md
# edit_ctrl

Mode controller and button front end for the hex operand editor on the Nexys4 board. Debounces the five raw push-buttons into single-cycle `BTN_OK` pulses and runs the VIEW → EDIT_A → EDIT_B mode state machine. It drives the editor's `ctrl[3:0]` and selects which value the seven-segment display shows. It sits between the board pins and the editor / display mux.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles (10 ms at 100 MHz) required before a button level is accepted; minimum 2.
- `TIMEOUT_CYCLES`, default 500_000_000: edit-mode inactivity limit (5 s), after which the block returns to VIEW; 0 disables the timeout.

Ports:
- `clk`, input, 1: system clock; the only clock in the block.
- `rst`, input, 1: synchronous, active-high reset.
- `btn_raw`, input, 5: asynchronous raw buttons.
  - [4] left, [3] up, [2] right, [1] down, [0] centre.
- `BTN_OK`, output, 5: single-cycle debounced press pulses to the editor; bit 0 is always 0.
- `ctrl`, output, 4: editor control.
  - VIEW = 4'b0000, EDIT_A = 4'b0001, EDIT_B = 4'b0011.
- `disp_sel`, output, 2: display source.
  - 0 = A, 1 = B, 2 = result; 3 is unused.
- `mode`, output, 2: current state.
  - VIEW = 0, EDIT_A = 1, EDIT_B = 2.

## Operation

Debounce, per button:
- Two-flop synchronizer.
- Counter of width $clog2(DEBOUNCE_CYCLES).
- Registered `stable` level, reset value 0.
- When the synchronized level equals `stable`, the counter clears.
- Otherwise the counter increments. On the cycle it reaches DEBOUNCE_CYCLES-1, `stable` takes the new level and the counter clears.
- `press[i]` is one cycle high on each 0→1 transition of `stable[i]`. Releases produce no pulse.

Mode FSM (states VIEW, EDIT_A, EDIT_B; reset state VIEW):
- `press[0]` advances VIEW → EDIT_A → EDIT_B → VIEW.
- Timeout, in EDIT_A or EDIT_B only:
  - An inactivity counter clears on any `press` bit and on every state change.
  - It otherwise increments, saturating.
  - When it reaches TIMEOUT_CYCLES-1, the next state is VIEW.
  - The counter holds at 0 in VIEW.
- If `press[0]` and the timeout fire in the same cycle, `press[0]` wins.

Pulse forwarding:
- `BTN_OK[4:1]` is registered as `press[4:1]`, but only when the current state is EDIT_A or EDIT_B and `press[0]` is 0 that cycle.
- Otherwise all `BTN_OK` bits are 0.
- Multiple arrow pulses in one cycle are forwarded together. The editor resolves priority.

Outputs:
- `ctrl`, `disp_sel` and `mode` are decoded from the state register.
- State mapping: VIEW → disp_sel 2, EDIT_A → 0, EDIT_B → 1.

## Timing

Reset values:
- Every register clears on `rst` asserted at a `clk` edge: synchronizers, counters, `stable`, inactivity counter, state = VIEW, `BTN_OK` = 0.
- Resulting outputs: `ctrl` = 0, `disp_sel` = 2, `mode` = 0.
- Reset mid-debounce or mid-edit discards all progress. A button held through reset release is seen as a fresh press after the full latency.

Press latency:
- `btn_raw[i]` rises before edge 0 and is held.
- `stable[i]` rises at edge DEBOUNCE_CYCLES+1.
- The `press` pulse is combinational from `stable` and the previous `stable`.
- `BTN_OK[i]` is high for exactly the cycle after edge DEBOUNCE_CYCLES+2.

Mode-change latency:
- The state register updates on the same edge that registers `BTN_OK`.
- `ctrl`, `disp_sel` and `mode` change DEBOUNCE_CYCLES+2 edges after centre-press sampling.

Glitch rejection:
- Any pulse shorter than DEBOUNCE_CYCLES synchronized cycles produces no output.
- Bounce resets the counter.

Timeout:
- VIEW is entered on the edge after the inactivity count reaches TIMEOUT_CYCLES-1.
- That is TIMEOUT_CYCLES edges after the last press or state change.

## Structure

- The shared package `edit_ctrl_pkg` holds:
  - the `mode_t` enum (VIEW, EDIT_A, EDIT_B);
  - the CTRL_VIEW, CTRL_EDIT_A and CTRL_EDIT_B constants;
  - the DISP_A, DISP_B and DISP_RES constants;
  - button index constants BTN_C=0, BTN_D=1, BTN_R=2, BTN_U=3, BTN_L=4.
- Sub-module `btn_debounce`:
  - Ports: `clk`, `rst`, `raw`, `stable`, `press`; parameter DEBOUNCE_CYCLES.
  - Contains the synchronizer, counter and edge detect.
  - Instantiated five times.
- `edit_ctrl` contains the FSM, the inactivity counter and the output registers.

## Test plan

Bench parameters: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20.

- Reset check: hold `rst` for 3 cycles with `btn_raw`=5'b11111. Expect `ctrl`=0, `disp_sel`=2, `mode`=0 and `BTN_OK`=0 during reset. After release, nothing happens in VIEW except a centre press 7 cycles later, giving `mode`=1.
- Centre sequencing and glitch rejection:
  - Three clean centre presses give `mode` 1→2→0 and `ctrl` 0001→0011→0000.
  - A 3-cycle centre glitch causes no change.
- Arrow forwarding: in EDIT_A, press up. Expect `BTN_OK`=5'b01000 for exactly 1 cycle, at the 7th edge after the raw rise. The same press in VIEW gives `BTN_OK`=0.
- Simultaneous centre and left: both `btn_raw` bits rise together in EDIT_A. Expect `mode`→2 and `BTN_OK` to stay 0.
- Timeout: enter EDIT_B with no further presses. Expect `mode`=0 exactly 20 edges after entry. A press at edge 15 restarts the count, giving VIEW 20 edges after that press.
- Reset mid-operation: `rst` pulsed 2 cycles into a debounce count while in EDIT_B. Expect `mode`=0 and no `BTN_OK` pulse. The still-held button pulses 7 edges after reset release, and is suppressed because the block is in VIEW.
